// File: rtl/seg_codes_pkg.sv
// Shared constants for the 7-segment scan receiver: segment bit positions,
// the recognised segment patterns, character codes and FSM state encoding.
package seg_codes_pkg;

    localparam int unsigned SEG_UPPER       = 7;
    localparam int unsigned SEG_RIGHT_UPPER = 6;
    localparam int unsigned SEG_RIGHT_LOWER = 5;
    localparam int unsigned SEG_LOWER       = 4;
    localparam int unsigned SEG_LEFT_LOWER  = 3;
    localparam int unsigned SEG_LEFT_UPPER  = 2;
    localparam int unsigned SEG_CENTER      = 1;
    localparam int unsigned SEG_DOT         = 0;

    localparam logic [7:0] PAT_0     = 8'hFC;
    localparam logic [7:0] PAT_1     = 8'h60;
    localparam logic [7:0] PAT_2     = 8'hDA;
    localparam logic [7:0] PAT_3     = 8'hF2;
    localparam logic [7:0] PAT_4     = 8'h66;
    localparam logic [7:0] PAT_5     = 8'hB6;
    localparam logic [7:0] PAT_6     = 8'hBE;
    localparam logic [7:0] PAT_7     = 8'hE0;
    localparam logic [7:0] PAT_8     = 8'hFE;
    localparam logic [7:0] PAT_9     = 8'hF6;
    localparam logic [7:0] PAT_A     = 8'hEE;
    localparam logic [7:0] PAT_B     = 8'h3E;
    localparam logic [7:0] PAT_C     = 8'h9C;
    localparam logic [7:0] PAT_D     = 8'h7A;
    localparam logic [7:0] PAT_E     = 8'h9E;
    localparam logic [7:0] PAT_F     = 8'h8E;
    localparam logic [7:0] PAT_H     = 8'h6E;
    localparam logic [7:0] PAT_L     = 8'h1C;
    localparam logic [7:0] PAT_BLANK = 8'h00;

    localparam logic [4:0] CH_H     = 5'h10;
    localparam logic [4:0] CH_L     = 5'h11;
    localparam logic [4:0] CH_BLANK = 5'h12;
    localparam logic [4:0] CH_UNK   = 5'h1F;

    typedef enum logic {
        IDLE    = 1'b0,
        CAPTURE = 1'b1
    } state_t;

endpackage

// File: rtl/seg_scan_capture_if.sv
// Scan-side inputs and published-frame outputs of the scan capture block.
interface seg_scan_capture_if;
  logic        SCAN_VALID;
  logic [7:0]  SEL_IN;
  logic [7:0]  SEG_IN;
  logic [63:0] FRAME_OUT;
  logic [39:0] CHAR_OUT;
  logic [7:0]  DOT_OUT;
  logic        FRAME_VALID;
  logic        SEQ_ERR;
  logic        BUSY;

  modport master (
    output SCAN_VALID, SEL_IN, SEG_IN,
    input  FRAME_OUT, CHAR_OUT, DOT_OUT, FRAME_VALID, SEQ_ERR, BUSY
  );

  modport slave (
    input  SCAN_VALID, SEL_IN, SEG_IN,
    output FRAME_OUT, CHAR_OUT, DOT_OUT, FRAME_VALID, SEQ_ERR, BUSY
  );
endinterface

// File: rtl/seg_char_decode.sv
// Combinational decoder from one segment pattern to a 5-bit character code;
// the dot segment is ignored.
module seg_char_decode
  import seg_codes_pkg::*;
(
  input  logic [7:0] seg,
  output logic [4:0] code
);

  logic [7:0] body;

  // Drop the dot and map the remaining seven segments to a code.
  always_comb begin
    body                  = 8'h00;
    body[SEG_UPPER]       = seg[SEG_UPPER];
    body[SEG_RIGHT_UPPER] = seg[SEG_RIGHT_UPPER];
    body[SEG_RIGHT_LOWER] = seg[SEG_RIGHT_LOWER];
    body[SEG_LOWER]       = seg[SEG_LOWER];
    body[SEG_LEFT_LOWER]  = seg[SEG_LEFT_LOWER];
    body[SEG_LEFT_UPPER]  = seg[SEG_LEFT_UPPER];
    body[SEG_CENTER]      = seg[SEG_CENTER];
    code                  = CH_UNK;
    case (body)
      PAT_0:     code = 5'h00;
      PAT_1:     code = 5'h01;
      PAT_2:     code = 5'h02;
      PAT_3:     code = 5'h03;
      PAT_4:     code = 5'h04;
      PAT_5:     code = 5'h05;
      PAT_6:     code = 5'h06;
      PAT_7:     code = 5'h07;
      PAT_8:     code = 5'h08;
      PAT_9:     code = 5'h09;
      PAT_A:     code = 5'h0A;
      PAT_B:     code = 5'h0B;
      PAT_C:     code = 5'h0C;
      PAT_D:     code = 5'h0D;
      PAT_E:     code = 5'h0E;
      PAT_F:     code = 5'h0F;
      PAT_H:     code = CH_H;
      PAT_L:     code = CH_L;
      PAT_BLANK: code = CH_BLANK;
      default:   code = CH_UNK;
    endcase
  end

endmodule

// File: rtl/seg_scan_capture.sv
// Rebuilds 8-digit frames from a one-hot 7-segment scan and publishes a frame
// once it has repeated unchanged for STABLE_FRAMES consecutive scans.
module seg_scan_capture
  import seg_codes_pkg::*;
#(
  parameter int STABLE_FRAMES = 2,
  parameter int CNT_W         = 4
) (
  input  logic               CLK,
  input  logic               RST,
  seg_scan_capture_if.slave  bus
);

  localparam logic [CNT_W-1:0] STABLE = CNT_W'(STABLE_FRAMES);

  state_t           state;
  logic [7:0]       expect_sel;
  logic [55:0]      shadow;
  logic [63:0]      prev_frame;
  logic [CNT_W-1:0] stable_cnt;
  logic             published;
  logic [63:0]      frame_out;
  logic [39:0]      char_out;
  logic [7:0]       dot_out;
  logic             frame_valid;
  logic             seq_err;
  logic             busy;

  logic [63:0]      done_frame;
  logic [39:0]      done_chars;
  logic [7:0]       done_dots;
  logic [CNT_W-1:0] cnt_next;
  logic             publish;

  // Slot 7 is merged straight from the input so completion needs no extra cycle.
  always_comb begin
    done_frame = {bus.SEG_IN, shadow};
    done_dots  = 8'h00;
    for (int k = 0; k < 8; k++) begin
      done_dots[k] = done_frame[8*k + SEG_DOT];
    end
    if (done_frame == prev_frame) begin
      cnt_next = (stable_cnt >= STABLE) ? STABLE : stable_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_next = {{(CNT_W-1){1'b0}}, 1'b1};
    end
    publish = (cnt_next == STABLE) && ((done_frame != frame_out) || !published);
  end

  for (genvar g = 0; g < 8; g++) begin : g_dec
    seg_char_decode u_dec (
      .seg  (done_frame[8*g +: 8]),
      .code (done_chars[5*g +: 5])
    );
  end

  // Scan-order FSM, frame assembly, stability tracking and output registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      expect_sel  <= 8'h00;
      shadow      <= 56'h0;
      prev_frame  <= 64'h0;
      stable_cnt  <= '0;
      published   <= 1'b0;
      frame_out   <= 64'h0;
      char_out    <= 40'h0;
      dot_out     <= 8'h00;
      frame_valid <= 1'b0;
      seq_err     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      seq_err     <= 1'b0;
      if (bus.SCAN_VALID) begin
        case (state)
          IDLE: begin
            if (bus.SEL_IN == 8'h01) begin
              shadow     <= {48'h0, bus.SEG_IN};
              expect_sel <= 8'h02;
              state      <= CAPTURE;
              busy       <= 1'b1;
            end
          end
          CAPTURE: begin
            if (bus.SEL_IN == expect_sel) begin
              expect_sel <= {expect_sel[6:0], expect_sel[7]};
              if (expect_sel[7]) begin
                prev_frame <= done_frame;
                stable_cnt <= cnt_next;
                shadow     <= 56'h0;
                if (publish) begin
                  frame_out   <= done_frame;
                  char_out    <= done_chars;
                  dot_out     <= done_dots;
                  frame_valid <= 1'b1;
                  published   <= 1'b1;
                end
              end else begin
                for (int k = 0; k < 7; k++) begin
                  if (expect_sel[k]) begin
                    shadow[8*k +: 8] <= bus.SEG_IN;
                  end
                end
              end
            end else begin
              // A stray 8'h01 is treated as the start of a fresh frame.
              seq_err    <= 1'b1;
              stable_cnt <= '0;
              if (bus.SEL_IN == 8'h01) begin
                shadow     <= {48'h0, bus.SEG_IN};
                expect_sel <= 8'h02;
              end else begin
                shadow     <= 56'h0;
                expect_sel <= 8'h00;
                state      <= IDLE;
                busy       <= 1'b0;
              end
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.FRAME_OUT   = frame_out;
  assign bus.CHAR_OUT    = char_out;
  assign bus.DOT_OUT     = dot_out;
  assign bus.FRAME_VALID = frame_valid;
  assign bus.SEQ_ERR     = seq_err;
  assign bus.BUSY        = busy;

endmodule
